// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline register with a skid buffer.
//
// A main entry drives the output; a skid entry catches the one word that
// arrives while the downstream side is blocked. Every output comes straight
// from a flop, so there is no combinational path from in_valid/out_ready
// to in_ready or to the out_* signals.
//
// Parameters
//   WIDTH       payload width in bits (1..256)
//   CLEAR_DATA  1: payload registers zeroed on rst/flush, 0: payload held
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset, overrides everything
//   flush      discard both entries; beats push, pop and stall
//   stall      freeze the output (no pop), pushes still allowed
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   stage can accept (registered)
//   out_valid  main entry holds a payload (registered)
//   out_data   main entry payload (registered)
//   out_ready  downstream accepts
//   count      occupancy 0..2 (registered)
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no entries held, in_ready = 1
// ST_ONE   | main entry valid, skid empty, in_ready = 1
// ST_FULL  | main and skid valid, in_ready = 0

module pipe_skid_reg #(
   parameter int WIDTH      = 32,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] skid_data;
   logic             push;
   logic             pop;

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~stall;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         count     <= 2'd0;
         in_ready  <= 1'b1;
         if (CLEAR_DATA) begin
            out_data  <= '0;
            skid_data <= '0;
         end
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  state     <= ST_ONE;
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  count     <= 2'd1;
                  in_ready  <= 1'b1;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  out_data <= in_data;
               end else if (push) begin
                  // Downstream did not take main: park the new word in skid.
                  state     <= ST_FULL;
                  skid_data <= in_data;
                  count     <= 2'd2;
                  in_ready  <= 1'b0;
               end else if (pop) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
                  count     <= 2'd0;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a pop can move us.
               if (pop) begin
                  state    <= ST_ONE;
                  out_data <= skid_data;
                  count    <= 2'd1;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               out_valid <= 1'b0;
               count     <= 2'd0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: drives three pipe_skid_reg instances with common
// control signals (WIDTH 32/CLEAR_DATA 1, WIDTH 1/CLEAR_DATA 1,
// WIDTH 64/CLEAR_DATA 0) and checks them against constants in the directed
// tasks and against a queue model in the random task.

module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        rst, flush, stall, in_valid, out_ready;
   logic [63:0] in_data;

   logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
   logic [31:0] od_a;
   logic [0:0]  od_b;
   logic [63:0] od_c;
   logic [1:0]  cnt_a, cnt_b, cnt_c;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.WIDTH(32), .CLEAR_DATA(1'b1)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_data(in_data[31:0]), .in_ready(ir_a),
      .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready), .count(cnt_a));

   pipe_skid_reg #(.WIDTH(1), .CLEAR_DATA(1'b1)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_data(in_data[0:0]), .in_ready(ir_b),
      .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready), .count(cnt_b));

   pipe_skid_reg #(.WIDTH(64), .CLEAR_DATA(1'b0)) dut_c (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir_c),
      .out_valid(ov_c), .out_data(od_c), .out_ready(out_ready), .count(cnt_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; flush = 1'b0; stall = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ov_a !== 1'b0) begin fails++; $display("FAIL reset_ov_a: got %b expected 0", ov_a); end
      checks++; if (cnt_a !== 2'd0) begin fails++; $display("FAIL reset_cnt_a: got %0d expected 0", cnt_a); end
      checks++; if (ir_a !== 1'b1) begin fails++; $display("FAIL reset_ir_a: got %b expected 1", ir_a); end
      checks++; if (od_a !== 32'd0) begin fails++; $display("FAIL reset_od_a: got %0h expected 0", od_a); end
      checks++; if (od_b !== 1'b0) begin fails++; $display("FAIL reset_od_b: got %0h expected 0", od_b); end
      checks++; if (cnt_c !== 2'd0 || ov_c !== 1'b0 || ir_c !== 1'b1) begin
         fails++; $display("FAIL reset_c: got cnt=%0d ov=%b ir=%b expected 0 0 1", cnt_c, ov_c, ir_c);
      end
   endtask

   task automatic test_stream();
      logic [63:0] v;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v = 64'h11 * 64'(i + 1);
         in_valid = 1'b1; in_data = v;
         tick();
         checks++; if (od_a !== v[31:0]) begin fails++; $display("FAIL stream_od_a[%0d]: got %0h expected %0h", i, od_a, v[31:0]); end
         checks++; if (od_c !== v) begin fails++; $display("FAIL stream_od_c[%0d]: got %0h expected %0h", i, od_c, v); end
         checks++; if (cnt_a !== 2'd1 || ov_a !== 1'b1) begin fails++; $display("FAIL stream_cnt[%0d]: got cnt=%0d ov=%b expected 1 1", i, cnt_a, ov_a); end
         checks++; if (ir_a !== 1'b1) begin fails++; $display("FAIL stream_ir[%0d]: got %b expected 1", i, ir_a); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (cnt_a !== 2'd0 || ov_a !== 1'b0) begin fails++; $display("FAIL stream_drain: got cnt=%0d ov=%b expected 0 0", cnt_a, ov_a); end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 1'b1; in_data = 64'hA;
      tick();
      checks++; if (cnt_a !== 2'd1 || ir_a !== 1'b1) begin fails++; $display("FAIL bp_one: got cnt=%0d ir=%b expected 1 1", cnt_a, ir_a); end
      in_data = 64'hB;
      tick();
      checks++; if (cnt_a !== 2'd2 || ir_a !== 1'b0) begin fails++; $display("FAIL bp_full: got cnt=%0d ir=%b expected 2 0", cnt_a, ir_a); end
      checks++; if (cnt_c !== 2'd2 || ir_c !== 1'b0) begin fails++; $display("FAIL bp_full_c: got cnt=%0d ir=%b expected 2 0", cnt_c, ir_c); end
      in_data = 64'hC;
      tick();
      checks++; if (cnt_a !== 2'd2 || od_a !== 32'hA) begin fails++; $display("FAIL bp_hold: got cnt=%0d od=%0h expected 2 a", cnt_a, od_a); end
      out_ready = 1'b1;
      tick();
      checks++; if (od_a !== 32'hB || cnt_a !== 2'd1) begin fails++; $display("FAIL bp_out_b: got od=%0h cnt=%0d expected b 1", od_a, cnt_a); end
      tick();
      checks++; if (od_a !== 32'hC || cnt_a !== 2'd1) begin fails++; $display("FAIL bp_out_c: got od=%0h cnt=%0d expected c 1", od_a, cnt_a); end
      in_valid = 1'b0;
      tick();
      checks++; if (cnt_a !== 2'd0) begin fails++; $display("FAIL bp_drain: got cnt=%0d expected 0", cnt_a); end
   endtask

   task automatic test_stall();
      do_reset();
      in_valid = 1'b1; in_data = 64'h5;
      tick();
      in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (od_a !== 32'h5 || cnt_a !== 2'd1 || ov_a !== 1'b1) begin
            fails++; $display("FAIL stall_hold[%0d]: got od=%0h cnt=%0d ov=%b expected 5 1 1", i, od_a, cnt_a, ov_a);
         end
      end
      in_valid = 1'b1; in_data = 64'h6;
      tick();
      checks++; if (cnt_a !== 2'd2 || od_a !== 32'h5 || ir_a !== 1'b0) begin
         fails++; $display("FAIL stall_push: got cnt=%0d od=%0h ir=%b expected 2 5 0", cnt_a, od_a, ir_a);
      end
      in_valid = 1'b0; stall = 1'b0;
      tick();
      checks++; if (od_a !== 32'h6 || cnt_a !== 2'd1) begin fails++; $display("FAIL stall_release: got od=%0h cnt=%0d expected 6 1", od_a, cnt_a); end
      tick();
      checks++; if (cnt_a !== 2'd0) begin fails++; $display("FAIL stall_drain: got cnt=%0d expected 0", cnt_a); end
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1'b1; in_data = 64'h5A;
      tick();
      in_data = 64'h3C;
      tick();
      in_data = 64'h77; flush = 1'b1;
      tick();
      checks++; if (cnt_a !== 2'd0 || ov_a !== 1'b0 || ir_a !== 1'b1) begin
         fails++; $display("FAIL flush_state_a: got cnt=%0d ov=%b ir=%b expected 0 0 1", cnt_a, ov_a, ir_a);
      end
      checks++; if (od_a !== 32'd0) begin fails++; $display("FAIL flush_clear_a: got %0h expected 0", od_a); end
      checks++; if (od_c !== 64'h5A || cnt_c !== 2'd0) begin fails++; $display("FAIL flush_hold_c: got od=%0h cnt=%0d expected 5a 0", od_c, cnt_c); end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      checks++; if (ov_a !== 1'b0 || ov_c !== 1'b0) begin fails++; $display("FAIL flush_no77: got ov_a=%b ov_c=%b expected 0 0", ov_a, ov_c); end
      // stall and flush together from ONE
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h42;
      tick();
      stall = 1'b1; flush = 1'b1; out_ready = 1'b1;
      tick();
      checks++; if (cnt_a !== 2'd0 || ov_a !== 1'b0) begin fails++; $display("FAIL flush_stall: got cnt=%0d ov=%b expected 0 0", cnt_a, ov_a); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1'b1; in_data = 64'h91;
      tick();
      in_data = 64'h92;
      tick();
      in_data = 64'h93; out_ready = 1'b1; rst = 1'b1;
      tick();
      checks++; if (cnt_a !== 2'd0 || ov_a !== 1'b0 || ir_a !== 1'b1) begin
         fails++; $display("FAIL rstmid_a: got cnt=%0d ov=%b ir=%b expected 0 0 1", cnt_a, ov_a, ir_a);
      end
      checks++; if (od_c !== 64'h91 || ov_c !== 1'b0) begin fails++; $display("FAIL rstmid_hold_c: got od=%0h ov=%b expected 91 0", od_c, ov_c); end
      rst = 1'b0; out_ready = 1'b0; in_data = 64'hA1;
      tick();
      in_data = 64'hA2;
      tick();
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
      tick();
      checks++; if (cnt_a !== 2'd0 || ov_a !== 1'b0 || ir_a !== 1'b1) begin
         fails++; $display("FAIL rstflush_a: got cnt=%0d ov=%b ir=%b expected 0 0 1", cnt_a, ov_a, ir_a);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [63:0] q[$];
      logic [63:0] head;
      logic        m_push, m_pop;
      int          m_fail_prev;
      do_reset();
      q.delete();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         rst       = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 49) == 0);
         stall     = ($urandom_range(0, 6) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_data   = {$urandom, $urandom};
         m_push = in_valid && (q.size() < 2) && !flush;
         m_pop  = (q.size() > 0) && out_ready && !stall;
         tick();
         if (rst || flush) q.delete();
         else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(in_data);
         end
         m_fail_prev = fails;
         checks++; if (cnt_a !== 2'(q.size()) || cnt_b !== 2'(q.size()) || cnt_c !== 2'(q.size())) begin
            fails++; $display("FAIL rnd_count@%0d: got %0d/%0d/%0d expected %0d", cyc, cnt_a, cnt_b, cnt_c, q.size());
         end
         checks++; if (ov_a !== (q.size() > 0) || ov_b !== (q.size() > 0) || ov_c !== (q.size() > 0)) begin
            fails++; $display("FAIL rnd_valid@%0d: got %b/%b/%b expected %b", cyc, ov_a, ov_b, ov_c, q.size() > 0);
         end
         checks++; if (ir_a !== (q.size() != 2) || ir_b !== (q.size() != 2) || ir_c !== (q.size() != 2)) begin
            fails++; $display("FAIL rnd_ready@%0d: got %b/%b/%b expected %b", cyc, ir_a, ir_b, ir_c, q.size() != 2);
         end
         checks++; if (ir_a !== (cnt_a != 2'd2)) begin
            fails++; $display("FAIL rnd_ready_vs_count@%0d: got ir=%b cnt=%0d", cyc, ir_a, cnt_a);
         end
         if (q.size() > 0) begin
            head = q[0];
            checks++; if (od_a !== head[31:0]) begin fails++; $display("FAIL rnd_data_a@%0d: got %0h expected %0h", cyc, od_a, head[31:0]); end
            checks++; if (od_b !== head[0:0]) begin fails++; $display("FAIL rnd_data_b@%0d: got %0h expected %0h", cyc, od_b, head[0:0]); end
            checks++; if (od_c !== head) begin fails++; $display("FAIL rnd_data_c@%0d: got %0h expected %0h", cyc, od_c, head); end
         end
         if (fails - m_fail_prev > 0 && fails > 40) begin
            $display("FAIL rnd_abort: too many failures, stopping random phase at cycle %0d", cyc);
            break;
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
